ascon_job_sequencer: RTL and testbench

//  Job-level controller for the ASCON-128 encryption core (ascon_top). Accepts one job

---
 rtl/ascon_job_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ascon_job_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ascon_job_sequencer
//  Purpose  : Job-level controller for one ascon_top encryption core. Takes a
//             single job command (key, nonce, one AD block, plaintext block
//             count), sequences the core start/data_valid pins, streams
//             plaintext in and ciphertext out over valid/ready handshakes,
//             captures the tag and flags a hung core with a sticky error.
//  Ports    : clock_i/reset_i             clock, synchronous active-high reset
//             cmd_*                       job command handshake and fields
//             pt_*                        plaintext block input stream
//             ct_*                        ciphertext block output stream
//             tag_valid_o/tag_o           one-cycle tag pulse and tag value
//             err_o                       sticky timeout / bad-count error
//             core_*                      connection to ascon_top
//  Revision : 1.0  initial release
// ============================================================================
module ascon_job_sequencer #(
    parameter int INIT_LAT = 13,
    parameter int PB_LAT   = 7,
    parameter int MAX_BLK  = 15,
    parameter int TIMEOUT  = 64
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [127:0] cmd_key_i,
    input  logic [127:0] cmd_nonce_i,
    input  logic [127:0] cmd_ad_i,
    input  logic [3:0]   cmd_n_blk_i,
    input  logic         pt_valid_i,
    output logic         pt_ready_o,
    input  logic [127:0] pt_data_i,
    output logic         ct_valid_o,
    input  logic         ct_ready_i,
    output logic [127:0] ct_data_o,
    output logic         ct_last_o,
    output logic         tag_valid_o,
    output logic [127:0] tag_o,
    output logic         err_o,
    output logic         core_start_o,
    output logic         core_data_valid_o,
    output logic [127:0] core_data_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_nonce_o,
    input  logic [127:0] core_cipher_i,
    input  logic         core_cipher_valid_i,
    input  logic [127:0] core_tag_i,
    input  logic         core_end_i
);

    // One shared wait counter serves every latency/timeout phase.
    localparam int c_cnt_max = (TIMEOUT > INIT_LAT)
                             ? ((TIMEOUT > PB_LAT) ? TIMEOUT : PB_LAT)
                             : ((INIT_LAT > PB_LAT) ? INIT_LAT : PB_LAT);
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_init_lat = c_cnt_w'(INIT_LAT);
    localparam logic [c_cnt_w-1:0] c_pb_lat   = c_cnt_w'(PB_LAT);
    localparam logic [c_cnt_w-1:0] c_timeout  = c_cnt_w'(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [4:0]         c_max_blk  = 5'(MAX_BLK);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_start   = 3'd1;
    localparam logic [2:0] c_st_w_init  = 3'd2;
    localparam logic [2:0] c_st_ad      = 3'd3;
    localparam logic [2:0] c_st_w_ad    = 3'd4;
    localparam logic [2:0] c_st_pt_get  = 3'd5;
    localparam logic [2:0] c_st_pt_wait = 3'd6;
    localparam logic [2:0] c_st_w_end   = 3'd7;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [127:0]       r_key;
    logic [127:0]       r_nonce;
    logic [127:0]       r_ad;
    logic [3:0]         r_n_blk;
    logic [3:0]         r_blk_cnt;
    logic               r_ct_valid;
    logic [127:0]       r_ct_data;
    logic               r_ct_last;
    logic               r_tag_valid;
    logic [127:0]       r_tag;
    logic               r_err;

    logic               w_cmd_fire;
    logic               w_pt_ready;
    logic               w_pt_fire;
    logic               w_ct_load;
    logic               w_cnt_last;
    logic               w_blk_done;
    logic               w_n_blk_bad;
    logic               w_timeout;
    logic               w_tag_fire;
    logic [3:0]         w_blk_next;

    // The counter is loaded with N and the phase ends on the cycle it steps
    // from 1 to 0, so each wait phase lasts exactly N cycles.
    assign w_cnt_last  = (r_cnt <= c_cnt_one);
    assign w_pt_ready  = (r_state == c_st_pt_get) && !r_ct_valid;
    assign w_pt_fire   = pt_valid_i && w_pt_ready;
    assign w_ct_load   = (r_state == c_st_pt_wait) && core_cipher_valid_i;
    assign w_blk_next  = r_blk_cnt + 4'd1;
    assign w_blk_done  = (w_blk_next == r_n_blk);
    assign w_n_blk_bad = (cmd_n_blk_i == 4'd0) || ({1'b0, cmd_n_blk_i} > c_max_blk);
    assign w_tag_fire  = (r_state == c_st_w_end) && core_end_i;
    assign w_timeout   = w_cnt_last &&
                         (((r_state == c_st_pt_wait) && !core_cipher_valid_i) ||
                          ((r_state == c_st_w_end) && !core_end_i));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:    if (w_cmd_fire) w_state_next = c_st_start;
            c_st_start:   w_state_next = c_st_w_init;
            c_st_w_init:  if (w_cnt_last) w_state_next = c_st_ad;
            c_st_ad:      w_state_next = c_st_w_ad;
            c_st_w_ad:    if (w_cnt_last) w_state_next = c_st_pt_get;
            c_st_pt_get:  if (w_pt_fire) w_state_next = c_st_pt_wait;
            c_st_pt_wait: begin
                if (core_cipher_valid_i) begin
                    w_state_next = w_blk_done ? c_st_w_end : c_st_pt_get;
                end else if (w_cnt_last) begin
                    w_state_next = c_st_idle;
                end
            end
            c_st_w_end:   if (core_end_i || w_cnt_last) w_state_next = c_st_idle;
            default:      w_state_next = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // New commands are held off during the tag pulse so a back-to-back
        // command lands only after the previous job has fully reported.
        cmd_ready_o       = (r_state == c_st_idle) && !r_tag_valid;
        core_start_o      = (r_state == c_st_start);
        pt_ready_o        = w_pt_ready;
        core_data_valid_o = (r_state == c_st_ad) || w_pt_fire;
        core_data_o       = '0;
        if (r_state == c_st_ad) begin
            core_data_o = r_ad;
        end else if (r_state == c_st_pt_get) begin
            core_data_o = pt_data_i;
        end
    end

    assign w_cmd_fire = cmd_valid_i && cmd_ready_o;

    // ------------------------------------------------------------------------
    // Wait counter (saturates at zero)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                c_st_start:   r_cnt <= c_init_lat;
                c_st_ad:      r_cnt <= c_pb_lat;
                c_st_pt_get:  if (w_pt_fire) r_cnt <= c_timeout;
                c_st_pt_wait: begin
                    if (core_cipher_valid_i) begin
                        r_cnt <= c_timeout;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_st_w_init, c_st_w_ad, c_st_w_end: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - c_cnt_one;
                end
                default:      r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Job registers, block counter and error flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_key     <= '0;
            r_nonce   <= '0;
            r_ad      <= '0;
            r_n_blk   <= '0;
            r_blk_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_cmd_fire) begin
                r_key     <= cmd_key_i;
                r_nonce   <= cmd_nonce_i;
                r_ad      <= cmd_ad_i;
                // Out-of-range counts still run one block but report an error.
                r_n_blk   <= w_n_blk_bad ? 4'd1 : cmd_n_blk_i;
                r_blk_cnt <= '0;
                r_err     <= w_n_blk_bad;
            end else begin
                if (w_ct_load) r_blk_cnt <= w_blk_next;
                if (w_timeout) r_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Ciphertext slot: drain first, then load, so both can occur together.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_ct_valid <= 1'b0;
            r_ct_data  <= '0;
            r_ct_last  <= 1'b0;
        end else begin
            if (r_ct_valid && ct_ready_i) r_ct_valid <= 1'b0;
            if (w_ct_load) begin
                r_ct_valid <= 1'b1;
                r_ct_data  <= core_cipher_i;
                r_ct_last  <= w_blk_done;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Tag capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_tag_valid <= 1'b0;
            r_tag       <= '0;
        end else begin
            r_tag_valid <= w_tag_fire;
            if (w_tag_fire) r_tag <= core_tag_i;
        end
    end

    assign ct_valid_o   = r_ct_valid;
    assign ct_data_o    = r_ct_data;
    assign ct_last_o    = r_ct_last;
    assign tag_valid_o  = r_tag_valid;
    assign tag_o        = r_tag;
    assign err_o        = r_err;
    assign core_key_o   = r_key;
    assign core_nonce_o = r_nonce;

endmodule
`default_nettype wire

// File: tb/tb_ascon_job_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ascon_job_sequencer
//  Purpose  : Self-checking bench for ascon_job_sequencer with a behavioural
//             ascon_top stub. Expected ciphertext/last flags are queued as
//             plaintext is accepted and popped as ciphertext drains.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ascon_job_sequencer;

    localparam int INIT_LAT = 13;
    localparam int PB_LAT   = 7;
    localparam int MAX_BLK  = 15;
    localparam int TIMEOUT  = 64;

    localparam logic [127:0] TAG_MIX = 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    localparam logic [127:0] KEY_A   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] NONCE_A = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] AD_A    = 128'h00000000_00000000_00000041_53434f4e;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [127:0] cmd_key_i;
    logic [127:0] cmd_nonce_i;
    logic [127:0] cmd_ad_i;
    logic [3:0]   cmd_n_blk_i;
    logic         pt_valid_i;
    logic         pt_ready_o;
    logic [127:0] pt_data_i;
    logic         ct_valid_o;
    logic         ct_ready_i;
    logic [127:0] ct_data_o;
    logic         ct_last_o;
    logic         tag_valid_o;
    logic [127:0] tag_o;
    logic         err_o;
    logic         core_start_o;
    logic         core_data_valid_o;
    logic [127:0] core_data_o;
    logic [127:0] core_key_o;
    logic [127:0] core_nonce_o;
    logic [127:0] core_cipher_i = '0;
    logic         core_cipher_valid_i = 1'b0;
    logic [127:0] core_tag_i = '0;
    logic         core_end_i = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    ascon_job_sequencer #(
        .INIT_LAT (INIT_LAT),
        .PB_LAT   (PB_LAT),
        .MAX_BLK  (MAX_BLK),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock_i             (clock_i),
        .reset_i             (reset_i),
        .cmd_valid_i         (cmd_valid_i),
        .cmd_ready_o         (cmd_ready_o),
        .cmd_key_i           (cmd_key_i),
        .cmd_nonce_i         (cmd_nonce_i),
        .cmd_ad_i            (cmd_ad_i),
        .cmd_n_blk_i         (cmd_n_blk_i),
        .pt_valid_i          (pt_valid_i),
        .pt_ready_o          (pt_ready_o),
        .pt_data_i           (pt_data_i),
        .ct_valid_o          (ct_valid_o),
        .ct_ready_i          (ct_ready_i),
        .ct_data_o           (ct_data_o),
        .ct_last_o           (ct_last_o),
        .tag_valid_o         (tag_valid_o),
        .tag_o               (tag_o),
        .err_o               (err_o),
        .core_start_o        (core_start_o),
        .core_data_valid_o   (core_data_valid_o),
        .core_data_o         (core_data_o),
        .core_key_o          (core_key_o),
        .core_nonce_o        (core_nonce_o),
        .core_cipher_i       (core_cipher_i),
        .core_cipher_valid_i (core_cipher_valid_i),
        .core_tag_i          (core_tag_i),
        .core_end_i          (core_end_i)
    );

    always #5 clock_i = ~clock_i;

    int cyc = 0;
    always @(posedge clock_i) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Core stub: ct = pt ^ acc, acc starts at key^nonce^ad and absorbs each pt,
    // tag = acc ^ TAG_MIX. Acts on the negedge, where DUT outputs are stable.
    // ------------------------------------------------------------------------
    bit           stub_dead = 1'b0;
    int           stub_lat  = 3;
    int           stub_nblk = 1;
    int           pend      = 0;
    int           end_cnt   = 0;
    int           stub_blk  = 0;
    bit           ad_next   = 1'b0;
    bit           dv_prev   = 1'b0;
    int           dv_viol   = 0;
    int           starts    = 0;
    int           start_cyc = 0;
    int           ad_cyc    = 0;
    logic [127:0] s_acc     = '0;
    logic [127:0] pend_data = '0;

    always @(negedge clock_i) begin
        core_cipher_valid_i = 1'b0;
        core_end_i          = 1'b0;
        if (reset_i) begin
            pend    = 0;
            end_cnt = 0;
            ad_next = 1'b0;
            dv_prev = 1'b0;
        end else begin
            if (end_cnt > 0) begin
                end_cnt--;
                if (end_cnt == 0) begin
                    core_end_i = 1'b1;
                    core_tag_i = s_acc ^ TAG_MIX;
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0 && !stub_dead) begin
                    core_cipher_valid_i = 1'b1;
                    core_cipher_i       = pend_data;
                    stub_blk++;
                    if (stub_blk == stub_nblk) end_cnt = 2;
                end
            end
            if (core_start_o) begin
                starts++;
                start_cyc = cyc;
                ad_next   = 1'b1;
                stub_blk  = 0;
                s_acc     = core_key_o ^ core_nonce_o;
            end
            if (core_data_valid_o) begin
                if (dv_prev) dv_viol++;
                if (ad_next) begin
                    ad_next = 1'b0;
                    ad_cyc  = cyc;
                    s_acc   = s_acc ^ core_data_o;
                end else begin
                    pend      = stub_lat;
                    pend_data = core_data_o ^ s_acc;
                    s_acc     = s_acc ^ core_data_o;
                end
            end
            dv_prev = core_data_valid_o;
        end
    end

    logic [127:0] cur_key, cur_nonce, cur_ad;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic send_cmd(input logic [127:0] key, input logic [127:0] nonce,
                            input logic [127:0] ad, input logic [3:0] n);
        int b = 0;
        while (!cmd_ready_o && b < 200) begin tick(); b++; end
        n_checks++;
        if (b >= 200) $display("FAIL send_cmd_ready: cmd_ready_o=%0b after %0d cycles, required 1", cmd_ready_o, b);
        else n_pass++;
        cur_key = key; cur_nonce = nonce; cur_ad = ad;
        cmd_key_i = key; cmd_nonce_i = nonce; cmd_ad_i = ad; cmd_n_blk_i = n;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    // Runs an accepted job to completion; ends in the tag cycle when all ct drained.
    task automatic run_job(input int n_eff, input int hold, input bit exp_err, output int held);
        logic [127:0] exp_q[$];
        bit           last_q[$];
        logic [127:0] acc, pt, e_ct;
        bit           e_last;
        int           sent = 0, rx = 0, tags = 0, budget = 0;
        held = 0;
        acc  = cur_key ^ cur_nonce ^ cur_ad;
        n_checks++;
        if (err_o !== exp_err) $display("FAIL job_err_at_accept: err_o=%0b required %0b", err_o, exp_err);
        else n_pass++;
        pt = {$urandom, $urandom, $urandom, $urandom};
        while (budget < 2000) begin
            pt_valid_i = (sent < n_eff);
            pt_data_i  = pt;
            ct_ready_i = !(held < hold);
            if (ct_valid_o && !ct_ready_i) begin
                held++;
                n_checks++;
                if (pt_ready_o !== 1'b0) $display("FAIL pt_ready_slot_full: pt_ready_o=%0b required 0", pt_ready_o);
                else n_pass++;
            end
            if (pt_valid_i && pt_ready_o) begin
                exp_q.push_back(pt ^ acc);
                last_q.push_back(sent == n_eff - 1);
                acc = acc ^ pt;
                sent++;
                pt = {$urandom, $urandom, $urandom, $urandom};
            end
            if (ct_valid_o && ct_ready_i) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL ct_unexpected: ct_data_o=%h with no block outstanding", ct_data_o);
                end else begin
                    n_pass++;
                    e_ct   = exp_q.pop_front();
                    e_last = last_q.pop_front();
                    n_checks++;
                    if (ct_data_o !== e_ct) $display("FAIL ct_data[%0d]: got %h required %h", rx, ct_data_o, e_ct);
                    else n_pass++;
                    n_checks++;
                    if (ct_last_o !== e_last) $display("FAIL ct_last[%0d]: got %0b required %0b", rx, ct_last_o, e_last);
                    else n_pass++;
                end
                rx++;
            end
            if (tag_valid_o) begin
                tags++;
                n_checks++;
                if (tag_o !== (acc ^ TAG_MIX)) $display("FAIL tag: got %h required %h", tag_o, acc ^ TAG_MIX);
                else n_pass++;
            end
            if (tags >= 1 && rx >= n_eff) break;
            tick();
            budget++;
        end
        pt_valid_i = 1'b0;
        ct_ready_i = 1'b0;
        n_checks++;
        if (budget >= 2000) $display("FAIL job_timeout: job not complete after %0d cycles, tags=%0d rx=%0d", budget, tags, rx);
        else n_pass++;
        n_checks++;
        if (rx != n_eff) $display("FAIL ct_count: got %0d required %0d", rx, n_eff);
        else n_pass++;
        n_checks++;
        if (tags != 1) $display("FAIL tag_count: got %0d required 1", tags);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) tick();
        reset_i = 1'b0;
        n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL rst_cmd_ready: got %0b required 1", cmd_ready_o); else n_pass++;
        n_checks++; if (pt_ready_o !== 1'b0) $display("FAIL rst_pt_ready: got %0b required 0", pt_ready_o); else n_pass++;
        n_checks++; if (ct_valid_o !== 1'b0) $display("FAIL rst_ct_valid: got %0b required 0", ct_valid_o); else n_pass++;
        n_checks++; if (tag_valid_o !== 1'b0) $display("FAIL rst_tag_valid: got %0b required 0", tag_valid_o); else n_pass++;
        n_checks++; if (err_o !== 1'b0) $display("FAIL rst_err: got %0b required 0", err_o); else n_pass++;
        n_checks++; if (core_start_o !== 1'b0) $display("FAIL rst_core_start: got %0b required 0", core_start_o); else n_pass++;
        n_checks++; if (core_data_valid_o !== 1'b0) $display("FAIL rst_core_dv: got %0b required 0", core_data_valid_o); else n_pass++;
        n_checks++; if (core_data_o !== '0) $display("FAIL rst_core_data: got %h required 0", core_data_o); else n_pass++;
        n_checks++; if (core_key_o !== '0) $display("FAIL rst_core_key: got %h required 0", core_key_o); else n_pass++;
        n_checks++; if (tag_o !== '0) $display("FAIL rst_tag: got %h required 0", tag_o); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int b = 0, seen = 0;
        stub_nblk = 2;
        send_cmd(KEY_A, NONCE_A, AD_A, 4'd2);
        while (!pt_ready_o && b < 200) begin tick(); b++; end
        pt_valid_i = 1'b1;
        pt_data_i  = 128'h1234;
        tick();
        pt_valid_i = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL midrst_cmd_ready: got %0b required 1", cmd_ready_o); else n_pass++;
        n_checks++; if (ct_valid_o !== 1'b0) $display("FAIL midrst_ct_valid: got %0b required 0", ct_valid_o); else n_pass++;
        n_checks++; if (tag_valid_o !== 1'b0) $display("FAIL midrst_tag_valid: got %0b required 0", tag_valid_o); else n_pass++;
        for (int i = 0; i < 12; i++) begin
            if (ct_valid_o || tag_valid_o || core_start_o) seen++;
            tick();
        end
        n_checks++; if (seen != 0) $display("FAIL midrst_quiet: %0d active cycles after reset, required 0", seen); else n_pass++;
    endtask

    task automatic test_single_block();
        int held;
        starts    = 0;
        stub_nblk = 1;
        send_cmd(KEY_A, NONCE_A, AD_A, 4'd1);
        run_job(1, 0, 1'b0, held);
        n_checks++; if (starts != 1) $display("FAIL single_start_pulses: got %0d required 1", starts); else n_pass++;
        n_checks++;
        if (ad_cyc - start_cyc != INIT_LAT + 1) $display("FAIL single_ad_latency: got %0d required %0d", ad_cyc - start_cyc, INIT_LAT + 1);
        else n_pass++;
        tick();
    endtask

    task automatic test_backpressure();
        int held;
        stub_nblk = 3;
        send_cmd(KEY_A ^ 128'hff, NONCE_A, 128'h77, 4'd3);
        run_job(3, 20, 1'b0, held);
        n_checks++; if (held != 20) $display("FAIL bp_held_cycles: got %0d required 20", held); else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        int b = 0, n = 0, held;
        stub_dead = 1'b1;
        stub_nblk = 1;
        send_cmd(KEY_A, NONCE_A, AD_A, 4'd1);
        while (!pt_ready_o && b < 200) begin tick(); b++; end
        pt_valid_i = 1'b1;
        pt_data_i  = 128'hdead;
        tick();
        pt_valid_i = 1'b0;
        while (!err_o && n < 300) begin tick(); n++; end
        n_checks++; if (n != TIMEOUT) $display("FAIL timeout_cycles: got %0d required %0d", n, TIMEOUT); else n_pass++;
        n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL timeout_idle: cmd_ready_o=%0b required 1", cmd_ready_o); else n_pass++;
        n_checks++; if (ct_valid_o !== 1'b0) $display("FAIL timeout_ct: ct_valid_o=%0b required 0", ct_valid_o); else n_pass++;
        stub_dead = 1'b0;
        tick();
        send_cmd(KEY_A, NONCE_A ^ 128'h5, AD_A, 4'd1);
        run_job(1, 0, 1'b0, held);
        tick();
    endtask

    task automatic test_back_to_back();
        int held;
        stub_nblk = 1;
        send_cmd(KEY_A, NONCE_A, AD_A, 4'd0);
        run_job(1, 0, 1'b1, held);
        cur_key = ~KEY_A; cur_nonce = NONCE_A; cur_ad = AD_A;
        cmd_key_i = ~KEY_A; cmd_nonce_i = NONCE_A; cmd_ad_i = AD_A; cmd_n_blk_i = 4'd2;
        cmd_valid_i = 1'b1;
        stub_nblk   = 2;
        n_checks++; if (cmd_ready_o !== 1'b0) $display("FAIL b2b_ready_in_tag_cycle: got %0b required 0", cmd_ready_o); else n_pass++;
        tick();
        n_checks++; if (cmd_ready_o !== 1'b1) $display("FAIL b2b_ready_after_tag: got %0b required 1", cmd_ready_o); else n_pass++;
        tick();
        cmd_valid_i = 1'b0;
        n_checks++; if (core_start_o !== 1'b1) $display("FAIL b2b_start: got %0b required 1", core_start_o); else n_pass++;
        run_job(2, 0, 1'b0, held);
        tick();
    endtask

    initial begin
        reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_key_i = '0; cmd_nonce_i = '0;
        cmd_ad_i = '0; cmd_n_blk_i = '0; pt_valid_i = 1'b0; pt_data_i = '0; ct_ready_i = 1'b0;
        test_reset();
        test_mid_reset();
        test_single_block();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        n_checks++; if (dv_viol != 0) $display("FAIL core_dv_consecutive: got %0d required 0", dv_viol); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
